wormhole_out_arbiter: RTL
=========================

# wormhole_out_arbiter

Per-output-port arbiter for the NoC switch. It shares one switch output among the `PORTS_NUM` input ports, including the local IP port, using round-robin arbitration. A grant is held for the whole packet (wormhole) until the tail flit is transferred. A watchdog force-releases a lock if a packet exceeds `MAX_PACK_LEN` flits without a tail. One instance sits in each `switch` per output port, between the input buffers and the output data mux.

## Interface
- `PORTS_NUM`, 5: number of requesters (input ports of the switch).
- `MAX_PACK_LEN`, 8 (`MAX_PACK_LEN` from configs.vh): maximum flits per packet, tail included.
- `IDX_W`, derived localparam: max(1, clog2(`PORTS_NUM`)).
- `CNT_W`, derived localparam: clog2(`MAX_PACK_LEN`+1).

Ports:
- `clk` in 1: single clock, rising edge.
- `a_rst` in 1: reset, asynchronous, active-high.
- `req` in `PORTS_NUM`: bit i means input i presents a flit routed to this output.
- `last` in `PORTS_NUM`: bit i means input i's presented flit is a tail. Qualified by `req`[i].
- `out_ready` in 1: downstream accepts a flit this cycle (neighbour `r_ready`).
- `grant` out `PORTS_NUM`: one-hot or zero, registered. Selects the data mux and the input pop.
- `grant_idx` out `IDX_W`: binary index of `grant`. Value is 0 when not locked.
- `locked` out 1: state is LOCKED.
- `xfer` out 1, combinational: `locked` & `req`[g] & `out_ready`, where g = `grant_idx`. A flit moves this cycle.
- `err` out 1, registered: one-cycle pulse when the watchdog fires.

## Operation
- **States:** IDLE and LOCKED.
- **IDLE:**
  - If `req` is nonzero, pick the first set bit scanning from `ptr` upward with wrap-around.
  - Load `grant`/`grant_idx` and go to LOCKED on the next edge. `xfer` is 0 in IDLE.
- **LOCKED:** `grant` is held regardless of other requests.
  - On `xfer` & `last`[g]: go to IDLE, clear `grant` and `cnt`, set `ptr` = (g+1) mod `PORTS_NUM`.
  - On `xfer` & !`last`[g]: `cnt` increments.
  - If `cnt` reaches `MAX_PACK_LEN`-1 on a non-tail `xfer`: pulse `err`, force IDLE, set `ptr` = g+1.
- **Requester dropout:** if `req`[g] drops while LOCKED, stay locked, `xfer` = 0. There is no timeout on idle cycles.
- **`out_ready` low:** state, `grant` and `cnt` are all held.
- **Requests from non-granted ports:** ignored while LOCKED. No pre-emption.
- **Pointer:** `ptr` (`IDX_W` bits) changes only on release, whether by tail or by watchdog. This guarantees starvation freedom: every continuously requesting port is served within `PORTS_NUM`-1 packets.
- **`PORTS_NUM` = 1:** degenerate but must work. `ptr` stays 0.
- **Reset values:** state IDLE, `grant` 0, `grant_idx` 0, `locked` 0, `err` 0, `ptr` 0, `cnt` 0.
- **Reset mid-packet:** the lock is dropped immediately, asynchronously. The partial packet is the input buffer's concern.

## Timing
- Request to grant: 1 cycle. First `xfer` is possible in the first LOCKED cycle.
- Single-flit packet with `out_ready` high: `req` at cycle 0, grant at cycle 1, `xfer` at cycle 1, IDLE at cycle 2.
- A tail transfer is always followed by one IDLE bubble cycle. The next grant appears 2 cycles after the tail `xfer`.
- Back-to-back N-flit packets with no stalls: N+1 cycles per packet.
- `err` is asserted the cycle after the offending `xfer`. `locked` is 0 in that same cycle.
- `xfer` is combinational from `req`, `out_ready` and the registered `grant`. There are no other combinational paths.

## Structure
- `PORTS_NUM`, `MAX_PACK_LEN` and the flit layout constants stay in configs.vh. Add `ARB_IDX_W(n)` there as a width macro. Nothing else is shared.
- One sub-module, `rr_picker`: purely combinational, inputs `req` and `ptr`, outputs a one-hot pick and its index. It is reused by future input-VC arbiters.
- The top-level FSM, `ptr`, `cnt` and `err` live in `wormhole_out_arbiter`. Target is about 150–250 lines of RTL total.

## Test plan
- **Reset:** assert `a_rst` mid-cycle with `req`=5'b11111. Outputs clear immediately. After release, `grant`=5'b00001 one cycle later.
- **Round-robin:** `req`=5'b10110 held, all single-flit tails, `out_ready`=1. Grant order is 1, 2, 4, 1, 2. Each grant lasts 1 cycle with 1 bubble between grants.
- **Wormhole hold:**
  - Port 3 sends 4 flits, tail on the 4th. Port 0 requests throughout. `out_ready` toggles 1,0,1,0,…
  - Required: `grant` stays 5'b01000 for 8 cycles and exactly 4 `xfer` pulses occur. Port 0 is granted 2 cycles after the tail.
- **Backpressure:** `out_ready`=0 for 10 cycles while locked. No `xfer`, `cnt` unchanged, `grant` stable.
- **Watchdog:**
  - `MAX_PACK_LEN`=8. Port 2 sends 8 flits with no tail.
  - Required: `err` pulses 1 cycle after the 8th `xfer`, `locked` goes to 0, next grant goes to port 3 or the first requester above it.
- **Fairness soak:** all ports request random-length packets of 1–8 flits for 10k cycles. No port waits more than 4 packets. The `grant` one-hot invariant holds every cycle.

Source files
------------

// File: rtl/wormhole_out_arbiter_pkg.sv
// Shared constants, state encoding and width helpers for the wormhole output arbiter
// and its round-robin picker.
package wormhole_out_arbiter_pkg;

  localparam int ARB_PORTS_NUM    = 5;
  localparam int ARB_MAX_PACK_LEN = 8;

  typedef logic [0:0] arb_state_t;

  localparam arb_state_t ARB_IDLE   = 1'b0;
  localparam arb_state_t ARB_LOCKED = 1'b1;

  // A single requester still needs a one-bit index so ports never collapse to zero width.
  function automatic int arb_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int arb_cnt_w(input int max_len);
    return $clog2(max_len + 1);
  endfunction

endpackage

// File: rtl/wormhole_out_arbiter_if.sv
// Request/grant bundle between the input buffers, the output arbiter and the output mux.
interface wormhole_out_arbiter_if
  import wormhole_out_arbiter_pkg::*;
#(
  parameter int PORTS_NUM = ARB_PORTS_NUM
) ();

  localparam int IDX_W = arb_idx_w(PORTS_NUM);

  logic [PORTS_NUM-1:0] req;
  logic [PORTS_NUM-1:0] last;
  logic                 out_ready;
  logic [PORTS_NUM-1:0] grant;
  logic [IDX_W-1:0]     grant_idx;
  logic                 locked;
  logic                 xfer;
  logic                 err;

  modport master (
    output req, last, out_ready,
    input  grant, grant_idx, locked, xfer, err
  );

  modport slave (
    input  req, last, out_ready,
    output grant, grant_idx, locked, xfer, err
  );

endinterface

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set bit of req at or above ptr, wrapping around.
module rr_picker
  import wormhole_out_arbiter_pkg::*;
#(
  parameter int PORTS_NUM = ARB_PORTS_NUM,
  parameter int IDX_W     = arb_idx_w(PORTS_NUM)
) (
  input  logic [PORTS_NUM-1:0] req,
  input  logic [IDX_W-1:0]     ptr,
  output logic [PORTS_NUM-1:0] pick,
  output logic [IDX_W-1:0]     pick_idx
);

  logic found;
  int   cand;

  // Walk priority offsets from ptr; the inner loop keeps every bit select constant.
  always_comb begin
    pick     = '0;
    pick_idx = '0;
    found    = 1'b0;
    cand     = 0;
    for (int off = 0; off < PORTS_NUM; off++) begin
      cand = int'(ptr) + off;
      if (cand >= PORTS_NUM) begin
        cand = cand - PORTS_NUM;
      end
      for (int i = 0; i < PORTS_NUM; i++) begin
        if (!found && req[i] && (i == cand)) begin
          found    = 1'b1;
          pick[i]  = 1'b1;
          pick_idx = IDX_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/wormhole_out_arbiter.sv
// Per-output wormhole arbiter: round-robin grant held until the tail flit moves,
// with a watchdog that force-releases packets running past the maximum length.
module wormhole_out_arbiter
  import wormhole_out_arbiter_pkg::*;
#(
  parameter int PORTS_NUM    = ARB_PORTS_NUM,
  parameter int MAX_PACK_LEN = ARB_MAX_PACK_LEN
) (
  input logic                    clk,
  input logic                    a_rst,
  wormhole_out_arbiter_if.slave  bus
);

  localparam int IDX_W = arb_idx_w(PORTS_NUM);
  localparam int CNT_W = arb_cnt_w(MAX_PACK_LEN);

  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MAX_PACK_LEN - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(PORTS_NUM - 1);

  arb_state_t           state;
  logic [IDX_W-1:0]     ptr;
  logic [CNT_W-1:0]     cnt;
  logic [PORTS_NUM-1:0] pick;
  logic [IDX_W-1:0]     pick_idx;
  logic [IDX_W-1:0]     ptr_after;
  logic                 tail_g;

  rr_picker #(
    .PORTS_NUM (PORTS_NUM),
    .IDX_W     (IDX_W)
  ) u_picker (
    .req      (bus.req),
    .ptr      (ptr),
    .pick     (pick),
    .pick_idx (pick_idx)
  );

  // grant is one-hot while locked, so masking with it selects the owner's bits.
  assign bus.locked = (state == ARB_LOCKED);
  assign bus.xfer   = bus.locked & (|(bus.req & bus.grant)) & bus.out_ready;
  assign tail_g     = |(bus.last & bus.grant);
  assign ptr_after  = (bus.grant_idx == LAST_IDX) ? '0 : bus.grant_idx + IDX_W'(1);

  // Release by tail or watchdog both hand priority to the port after the owner.
  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      state         <= ARB_IDLE;
      bus.grant     <= '0;
      bus.grant_idx <= '0;
      bus.err       <= 1'b0;
      ptr           <= '0;
      cnt           <= '0;
    end else begin
      bus.err <= 1'b0;
      case (state)
        ARB_IDLE: begin
          if (|bus.req) begin
            state         <= ARB_LOCKED;
            bus.grant     <= pick;
            bus.grant_idx <= pick_idx;
            cnt           <= '0;
          end
        end
        ARB_LOCKED: begin
          if (bus.xfer) begin
            if (tail_g || (cnt == CNT_LIMIT)) begin
              state         <= ARB_IDLE;
              bus.grant     <= '0;
              bus.grant_idx <= '0;
              cnt           <= '0;
              ptr           <= ptr_after;
              bus.err       <= !tail_g;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule
